// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified-memory arbiter.
// slave: the arbiter's view; master: the pipeline/memory environment's view.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [BE_W-1:0]   d_be_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  logic              bus_err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i, mem_ready_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output bus_err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output mem_rdata_i, mem_ready_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  bus_err_o
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory between fetch and MEM-stage data ports.
// Define RV32I_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_STREAK data grants.
module rv32i_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int TIMEOUT         = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                 clk_i,
  input logic                 resetn_i,
  rv32i_mem_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] NOP_INSN  = DATA_W'(32'h0000_0013);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  state_t            state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              we_reg, we_next;
  logic [BE_W-1:0]   be_reg, be_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              if_rvalid_reg, if_rvalid_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic              d_rvalid_reg, d_rvalid_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              bus_err_reg, bus_err_next;

  logic timeout_hit, complete, arb_open, starve_fetch, d_gnt, if_gnt;

  assign timeout_hit = (TIMEOUT != 0) && (state_reg == BUSY) && (tmo_cnt_reg == TMO_LIMIT);
  assign complete    = (state_reg == BUSY) && (bus.mem_ready_i || timeout_hit);
  assign arb_open    = (state_reg == IDLE) || complete;
  assign d_gnt       = arb_open && bus.d_req_i && !starve_fetch;
  assign if_gnt      = arb_open && bus.if_req_i && !d_gnt;

`ifdef RV32I_ARB_STARVE_GUARD_EN
  localparam int STRK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  logic [STRK_W-1:0] streak_reg, streak_next;

  // Data keeps priority until fetch has watched MAX_DATA_STREAK data grants in a row.
  assign starve_fetch = (streak_reg == STRK_W'(MAX_DATA_STREAK)) && bus.if_req_i && bus.d_req_i;

  always_comb begin
    streak_next = streak_reg;
    if (if_gnt || !bus.if_req_i) begin
      streak_next = '0;
    end else if (d_gnt) begin
      streak_next = streak_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end
`else
  assign starve_fetch = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    we_next        = we_reg;
    be_next        = be_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    if_rvalid_next = 1'b0;
    if_rdata_next  = if_rdata_reg;
    d_rvalid_next  = 1'b0;
    d_rdata_next   = d_rdata_reg;
    bus_err_next   = bus_err_reg;

    if (complete) begin
      state_next = IDLE;
      owner_next = OWN_NONE;
      // A real ready wins over a timeout landing in the same cycle.
      if (owner_reg == OWN_FETCH) begin
        if_rvalid_next = 1'b1;
        if_rdata_next  = bus.mem_ready_i ? bus.mem_rdata_i : NOP_INSN;
      end else if (owner_reg == OWN_DATA) begin
        d_rvalid_next = 1'b1;
        d_rdata_next  = (we_reg || !bus.mem_ready_i) ? '0 : bus.mem_rdata_i;
      end
      if (!bus.mem_ready_i) begin
        bus_err_next = 1'b1;
      end
    end else if (state_reg == BUSY) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end

    if (d_gnt) begin
      state_next   = BUSY;
      owner_next   = OWN_DATA;
      tmo_cnt_next = '0;
      we_next      = bus.d_we_i;
      be_next      = bus.d_be_i;
      addr_next    = bus.d_addr_i;
      wdata_next   = bus.d_wdata_i;
    end else if (if_gnt) begin
      state_next   = BUSY;
      owner_next   = OWN_FETCH;
      tmo_cnt_next = '0;
      we_next      = 1'b0;
      be_next      = '0;
      addr_next    = bus.if_addr_i;
      wdata_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_NONE;
      tmo_cnt_reg   <= '0;
      we_reg        <= 1'b0;
      be_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      if_rvalid_reg <= 1'b0;
      if_rdata_reg  <= '0;
      d_rvalid_reg  <= 1'b0;
      d_rdata_reg   <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      we_reg        <= we_next;
      be_reg        <= be_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      if_rvalid_reg <= if_rvalid_next;
      if_rdata_reg  <= if_rdata_next;
      d_rvalid_reg  <= d_rvalid_next;
      d_rdata_reg   <= d_rdata_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.if_rvalid_o = if_rvalid_reg;
  assign bus.if_rdata_o  = if_rdata_reg;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.d_rvalid_o  = d_rvalid_reg;
  assign bus.d_rdata_o   = d_rdata_reg;
  assign bus.mem_req_o   = (state_reg == BUSY);
  assign bus.mem_we_o    = we_reg;
  assign bus.mem_be_o    = be_reg;
  assign bus.mem_addr_o  = addr_reg;
  assign bus.mem_wdata_o = wdata_reg;
  assign bus.bus_err_o   = bus_err_reg;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench: grants push expected responses, a negedge monitor pops them on rvalid.
// Directed scenarios cover fetch, priority chaining, wait-state store, timeout, reset and streaks.
module tb_rv32i_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TIMEOUT = 16;
  localparam int MAX_DATA_STREAK = 4;

  logic clk_i = 1'b0;
  logic resetn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rv32i_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rv32i_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) dut (
    .clk_i(clk_i),
    .resetn_i(resetn_i),
    .bus(bus)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  bit   gnt_log[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   rv_total = 0;
  int   if_rv_cyc = -1, d_rv_cyc = -1;
  bit   tmo_mode = 0, log_en = 0;
  int   wait_states = 0;
  bit   ready_en = 1, idle_poke = 0;

`ifdef RV32I_ARB_STARVE_GUARD_EN
  bit guard_en = 1;
`else
  bit guard_en = 0;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
      $display("ok   %s = %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_model = 32'h0050_0093;
      32'h0000_0104: mem_model = 32'h00A0_0113;
      32'h0000_2000: mem_model = 32'h1122_3344;
      default:       mem_model = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory responder: ready after wait_states stall cycles, optional pokes while idle.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.mem_req_o && ready_en) begin
        if (wcnt >= wait_states) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = mem_model(bus.mem_addr_o);
          wcnt = 0;
        end else begin
          bus.mem_ready_i = 1'b0;
          bus.mem_rdata_i = '0;
          wcnt++;
        end
      end else if (!bus.mem_req_o && idle_poke) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        wcnt = 0;
      end else begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pop on rvalid first, then record any new grant's expected response.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (bus.if_rvalid_o || bus.d_rvalid_o) begin
      rv_total++;
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_data) begin
          check("d_rsp", {bus.d_rvalid_o, bus.if_rvalid_o, bus.d_rdata_o}, {1'b1, 1'b0, e.data});
          d_rv_cyc = cyc;
        end else begin
          check("if_rsp", {bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o}, {1'b1, 1'b0, e.data});
          if_rv_cyc = cyc;
        end
      end
    end
    if (bus.if_gnt_o || bus.d_gnt_o) begin
      check("gnt_onehot", bus.if_gnt_o & bus.d_gnt_o, 0);
      if (bus.d_gnt_o) begin
        e.is_data = 1'b1;
        e.data = (tmo_mode || bus.d_we_i) ? 32'h0 : mem_model(bus.d_addr_i);
        sb_q.push_back(e);
        if (log_en) gnt_log.push_back(1'b1);
      end
      if (bus.if_gnt_o) begin
        e.is_data = 1'b0;
        e.data = tmo_mode ? 32'h0000_0013 : mem_model(bus.if_addr_i);
        sb_q.push_back(e);
        if (log_en) gnt_log.push_back(1'b0);
      end
    end
  end

  task automatic wait_gnt(input bit is_data, output int gcyc);
    int n;
    n = 0;
    gcyc = -1;
    while (n < 200) begin
      @(negedge clk_i);
      if (is_data ? bus.d_gnt_o : bus.if_gnt_o) break;
      n++;
    end
    if (n >= 200) check(is_data ? "d_gnt_wait" : "if_gnt_wait", 0, 1);
    else gcyc = cyc;
    @(posedge clk_i);
    #1;
    if (is_data) bus.d_req_i = 1'b0;
    else bus.if_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, gd, gf, r0;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_be_i = '0; bus.d_addr_i = '0; bus.d_wdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_ctrl", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.if_gnt_o, bus.d_gnt_o,
                         bus.if_rvalid_o, bus.d_rvalid_o, bus.bus_err_o}, 0);
    check("reset_mem_bus", {bus.mem_addr_o, bus.mem_wdata_o}, 0);
    check("reset_rdata", {bus.if_rdata_o, bus.d_rdata_o}, 0);
    resetn_i = 1'b1;
    idle(1);

    // Single fetch, zero-wait memory
    bus.if_addr_i = 32'h100; bus.if_req_i = 1;
    wait_gnt(0, g);
    @(negedge clk_i);
    check("t1_mem_fields", {bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o},
          {1'b1, 32'h100, 1'b0, 4'h0, 32'h0});
    idle(4);
    check("t1_latency", if_rv_cyc - g, 2);

    // Simultaneous requests: data first, fetch chained with no bubble
    bus.d_addr_i = 32'h2000; bus.d_we_i = 0; bus.d_req_i = 1;
    bus.if_addr_i = 32'h100; bus.if_req_i = 1;
    fork
      wait_gnt(1, gd);
      wait_gnt(0, gf);
      begin
        @(negedge clk_i);
        check("t2_idle_c0", bus.mem_req_o, 0);
        @(negedge clk_i);
        check("t2_data_c1", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h2000});
      end
    join
    @(negedge clk_i);
    check("t2_fetch_c2", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h100});
    check("t2_gnt_gap", gf - gd, 1);
    idle(4);
    check("t2_d_rv", d_rv_cyc - gd, 2);
    check("t2_if_rv", if_rv_cyc - gd, 3);

    // Store with 3 wait states
    wait_states = 3;
    bus.d_we_i = 1; bus.d_be_i = 4'b0011; bus.d_wdata_i = 32'hCAFE_BABE; bus.d_addr_i = 32'h2004;
    bus.d_req_i = 1;
    wait_gnt(1, g);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check($sformatf("t3_hold%0d", k),
            {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
            {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hCAFE_BABE});
    end
    idle(3);
    check("t3_d_rv", d_rv_cyc - g, 5);
    wait_states = 0;
    bus.d_we_i = 0; bus.d_be_i = '0; bus.d_wdata_i = '0;

    // Timeout on a fetch
    ready_en = 0; tmo_mode = 1;
    bus.if_addr_i = 32'h300; bus.if_req_i = 1;
    wait_gnt(0, g);
    repeat (17) @(negedge clk_i);
    check("t4_still_busy", {bus.mem_req_o, bus.bus_err_o}, 2'b10);
    @(negedge clk_i);
    check("t4_forced", {bus.if_rvalid_o, bus.bus_err_o}, 2'b11);
    idle(5);
    check("t4_err_sticky", {bus.bus_err_o, bus.mem_req_o}, 2'b10);
    check("t4_rv_cycle", if_rv_cyc - g, 18);
    tmo_mode = 0; ready_en = 1;

    // Ready while idle is ignored
    r0 = rv_total;
    idle_poke = 1;
    idle(4);
    idle_poke = 0;
    idle(2);
    check("t5_idle_ready", {rv_total - r0, 31'(bus.mem_req_o)}, 0);

    // Reset mid-transaction
    ready_en = 0;
    r0 = rv_total;
    bus.if_addr_i = 32'h104; bus.if_req_i = 1;
    wait_gnt(0, g);
    @(posedge clk_i);
    #1;
    resetn_i = 0;
    #1;
    check("t6_rst_drop", {bus.mem_req_o, bus.bus_err_o, bus.if_rvalid_o}, 0);
    repeat (2) @(negedge clk_i);
    resetn_i = 1;
    ready_en = 1;
    idle(3);
    check("t6_no_rvalid", rv_total - r0, 0);
    check("t6_abandoned", sb_q.size(), 1);
    sb_q.delete();
    bus.if_addr_i = 32'h100; bus.if_req_i = 1;
    wait_gnt(0, g);
    idle(3);
    check("t6_after_rst", if_rv_cyc - g, 2);

    // Both requests held: strict priority, or 4 data then 1 fetch with the guard
    gnt_log.delete();
    log_en = 1;
    bus.d_addr_i = 32'h2000; bus.d_we_i = 0; bus.d_req_i = 1;
    bus.if_addr_i = 32'h100; bus.if_req_i = 1;
    idle(12);
    bus.d_req_i = 0; bus.if_req_i = 0;
    log_en = 0;
    idle(4);
    check("t7_gnt_count", gnt_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t7_gnt%0d_is_data", i), gnt_log[i], (guard_en && (i % 5 == 4)) ? 1'b0 : 1'b1);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
